// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width and the opcode encoding.
package alu_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_MUL  = 4'b0010,
        OP_DIV  = 4'b0011,
        OP_SHL  = 4'b0100,
        OP_SHR  = 4'b0101,
        OP_ROL  = 4'b0110,
        OP_ROR  = 4'b0111,
        OP_AND  = 4'b1000,
        OP_OR   = 4'b1001,
        OP_XOR  = 4'b1010,
        OP_NOR  = 4'b1011,
        OP_NAND = 4'b1100,
        OP_XNOR = 4'b1101,
        OP_GT   = 4'b1110,
        OP_EQ   = 4'b1111
    } alu_op_e;

endpackage

// File: rtl/alu8_comb.sv
// Combinational ALU core: result and carry/borrow/overflow for one opcode.
module alu8_comb
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic [WIDTH-1:0] z_c,
    output logic             carry_c
);

    localparam int unsigned PW = 2 * WIDTH;

    alu_op_e          op;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [PW-1:0]    prod;

    always_comb begin
        op      = alu_op_e'(sel);
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        prod    = PW'(a) * PW'(b);
        z_c     = '0;
        carry_c = 1'b0;
        case (op)
            OP_ADD: begin
                z_c     = sum[WIDTH-1:0];
                carry_c = sum[WIDTH];
            end
            OP_SUB: begin
                z_c     = diff[WIDTH-1:0];
                carry_c = diff[WIDTH];
            end
            OP_MUL: begin
                z_c     = prod[WIDTH-1:0];
                carry_c = |prod[PW-1:WIDTH];
            end
            // Divide by zero saturates and raises carry instead of producing X
            OP_DIV: begin
                if (b == '0) begin
                    z_c     = '1;
                    carry_c = 1'b1;
                end else begin
                    z_c = a / b;
                end
            end
            OP_SHL: begin
                z_c     = a << 1;
                carry_c = a[WIDTH-1];
            end
            OP_SHR: begin
                z_c     = a >> 1;
                carry_c = a[0];
            end
            OP_ROL: begin
                z_c     = {a[WIDTH-2:0], a[WIDTH-1]};
                carry_c = a[WIDTH-1];
            end
            OP_ROR: begin
                z_c     = {a[0], a[WIDTH-1:1]};
                carry_c = a[0];
            end
            OP_AND:  z_c = a & b;
            OP_OR:   z_c = a | b;
            OP_XOR:  z_c = a ^ b;
            OP_NOR:  z_c = ~(a | b);
            OP_NAND: z_c = ~(a & b);
            OP_XNOR: z_c = ~(a ^ b);
            OP_GT:   z_c = WIDTH'(a > b);
            OP_EQ:   z_c = WIDTH'(a == b);
        endcase
    end

endmodule

// File: rtl/alu8.sv
// Registered ALU execute stage: one-cycle latency, synchronous reset.
module alu8
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic [WIDTH-1:0] z,
    output logic             carry,
    output logic             zero
);

    logic [WIDTH-1:0] z_c;
    logic             carry_c;

    logic [WIDTH-1:0] z_d,     z_q;
    logic             carry_d, carry_q;
    logic             zero_d,  zero_q;

    alu8_comb #(.WIDTH(WIDTH)) u_comb (
        .a       (a),
        .b       (b),
        .sel     (sel),
        .z_c     (z_c),
        .carry_c (carry_c)
    );

    // zero is derived from the value about to be registered so it tracks z
    always_comb begin
        z_d     = z_c;
        carry_d = carry_c;
        zero_d  = (z_c == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            z_q     <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            z_q     <= z_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign z     = z_q;
    assign carry = carry_q;
    assign zero  = zero_q;

endmodule

// File: tb/tb_alu8.sv
// Self-checking bench for alu8: directed vector table, reset sequences and random vs. model.
module tb_alu8;
    import alu_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
    logic [7:0] z;
    logic       carry;
    logic       zero;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
        logic [7:0] z;
        logic       c;
        logic       zr;
    } vec_t;

    vec_t vecs[$];

    alu8 dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .sel   (sel),
        .z     (z),
        .carry (carry),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model written from the opcode rules using plain integer arithmetic
    function automatic void model(input int ia, input int ib, input int op,
                                  output logic [7:0] ez, output logic ec);
        int r;
        int c;
        r = 0;
        c = 0;
        case (op)
            0:  begin r = (ia + ib) % 256; c = (ia + ib > 255) ? 1 : 0; end
            1:  begin r = (ia - ib + 256) % 256; c = (ia < ib) ? 1 : 0; end
            2:  begin r = (ia * ib) % 256; c = (ia * ib > 255) ? 1 : 0; end
            3:  begin
                    if (ib == 0) begin r = 255; c = 1; end
                    else r = ia / ib;
                end
            4:  begin r = (ia * 2) % 256; c = ia / 128; end
            5:  begin r = ia / 2; c = ia % 2; end
            6:  begin r = (ia * 2) % 256 + ia / 128; c = ia / 128; end
            7:  begin r = ia / 2 + (ia % 2) * 128; c = ia % 2; end
            8:  r = ia & ib;
            9:  r = ia | ib;
            10: r = ia ^ ib;
            11: r = 255 - (ia | ib);
            12: r = 255 - (ia & ib);
            13: r = 255 - (ia ^ ib);
            14: r = (ia > ib) ? 1 : 0;
            default: r = (ia == ib) ? 1 : 0;
        endcase
        ez = 8'(r);
        ec = (c != 0);
    endfunction

    task automatic check(input string name, input logic [7:0] ez,
                         input logic ec, input logic ezr);
        checks++;
        if (z !== ez || carry !== ec || zero !== ezr) begin
            failures++;
            $display("FAIL %s: got z=%02h carry=%0b zero=%0b, expected z=%02h carry=%0b zero=%0b",
                     name, z, carry, zero, ez, ec, ezr);
        end
    endtask

    // Drive inputs away from the edge, then sample just after the next rising edge
    task automatic step(input logic r, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [3:0] op);
        @(negedge clk);
        rst = r;
        a   = ia;
        b   = ib;
        sel = op;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] ez;
        logic       ec;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [3:0] rop;

        rst = 1'b1;
        a   = 8'd0;
        b   = 8'd0;
        sel = 4'd0;

        // Reset held two cycles with a live ADD on the inputs
        step(1'b1, 8'd5, 8'd3, 4'(OP_ADD));
        check("reset_cycle0", 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'd5, 8'd3, 4'(OP_ADD));
        check("reset_cycle1", 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'd5, 8'd3, 4'(OP_ADD));
        check("reset_release_add", 8'h08, 1'b0, 1'b0);

        // Opcode sweep a=1 b=1
        vecs.push_back('{8'h01, 8'h01, 4'h0, 8'h02, 1'b0, 1'b0});
        vecs.push_back('{8'h01, 8'h01, 4'h1, 8'h00, 1'b0, 1'b1});
        vecs.push_back('{8'h01, 8'h01, 4'h2, 8'h01, 1'b0, 1'b0});
        vecs.push_back('{8'h01, 8'h01, 4'h3, 8'h01, 1'b0, 1'b0});
        vecs.push_back('{8'h01, 8'h01, 4'h4, 8'h02, 1'b0, 1'b0});
        vecs.push_back('{8'h01, 8'h01, 4'h5, 8'h00, 1'b1, 1'b1});
        vecs.push_back('{8'h01, 8'h01, 4'h6, 8'h02, 1'b0, 1'b0});
        vecs.push_back('{8'h01, 8'h01, 4'h7, 8'h80, 1'b1, 1'b0});
        vecs.push_back('{8'h01, 8'h01, 4'h8, 8'h01, 1'b0, 1'b0});
        vecs.push_back('{8'h01, 8'h01, 4'h9, 8'h01, 1'b0, 1'b0});
        vecs.push_back('{8'h01, 8'h01, 4'hA, 8'h00, 1'b0, 1'b1});
        vecs.push_back('{8'h01, 8'h01, 4'hB, 8'hFE, 1'b0, 1'b0});
        vecs.push_back('{8'h01, 8'h01, 4'hC, 8'hFE, 1'b0, 1'b0});
        vecs.push_back('{8'h01, 8'h01, 4'hD, 8'hFF, 1'b0, 1'b0});
        vecs.push_back('{8'h01, 8'h01, 4'hE, 8'h00, 1'b0, 1'b1});
        vecs.push_back('{8'h01, 8'h01, 4'hF, 8'h01, 1'b0, 1'b0});
        // Carry, divide and shift/rotate boundaries
        vecs.push_back('{8'hFF, 8'h01, 4'h0, 8'h00, 1'b1, 1'b1});
        vecs.push_back('{8'h00, 8'h01, 4'h1, 8'hFF, 1'b1, 1'b0});
        vecs.push_back('{8'h10, 8'h10, 4'h2, 8'h00, 1'b1, 1'b1});
        vecs.push_back('{8'd64,  8'd0,  4'h3, 8'hFF, 1'b1, 1'b0});
        vecs.push_back('{8'd64,  8'd7,  4'h3, 8'h09, 1'b0, 1'b0});
        vecs.push_back('{8'h81, 8'h00, 4'h4, 8'h02, 1'b1, 1'b0});
        vecs.push_back('{8'h81, 8'h00, 4'h5, 8'h40, 1'b1, 1'b0});
        vecs.push_back('{8'h81, 8'h00, 4'h6, 8'h03, 1'b1, 1'b0});
        vecs.push_back('{8'h81, 8'h00, 4'h7, 8'hC0, 1'b1, 1'b0});
        vecs.push_back('{8'h05, 8'h03, 4'hE, 8'h01, 1'b0, 1'b0});
        vecs.push_back('{8'h03, 8'h05, 4'hE, 8'h00, 1'b0, 1'b1});

        foreach (vecs[i]) begin
            step(1'b0, vecs[i].a, vecs[i].b, vecs[i].sel);
            check($sformatf("vec%0d_op%0h", i, vecs[i].sel), vecs[i].z, vecs[i].c, vecs[i].zr);
        end

        // Back-to-back ADD/XOR with a single-cycle reset mid-stream
        for (int i = 0; i < 12; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rop = (i % 2 == 0) ? 4'(OP_ADD) : 4'(OP_XOR);
            if (i == 6) begin
                step(1'b1, ra, rb, rop);
                check("midstream_reset", 8'h00, 1'b0, 1'b0);
            end else begin
                step(1'b0, ra, rb, rop);
                model(int'(ra), int'(rb), int'(rop), ez, ec);
                check($sformatf("b2b%0d", i), ez, ec, ez == 8'h00);
            end
        end

        // Random operands and opcodes against the model
        for (int i = 0; i < 300; i++) begin
            ra  = 8'($urandom);
            rb  = (i % 10 == 0) ? 8'h00 : 8'($urandom);
            rop = 4'($urandom_range(0, 15));
            step(1'b0, ra, rb, rop);
            model(int'(ra), int'(rb), int'(rop), ez, ec);
            check($sformatf("rand%0d_op%0h_a%02h_b%02h", i, rop, ra, rb), ez, ec, ez == 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
